// File: rtl/spr_sched_pkg.sv
// Shared types for the sprite scheduler: attribute entry, slot record, scan states
// and the per-entry visibility test. Coordinate and id widths are fixed here.
package spr_sched_pkg;

  localparam int CORDW = 16;
  localparam int IDW   = 4;

  typedef struct packed {
    logic signed [CORDW-1:0] x;
    logic signed [CORDW-1:0] y;
    logic [IDW-1:0]          id;
    logic                    en;
  } spr_attr_t;

  typedef struct packed {
    logic                    valid;
    logic signed [CORDW-1:0] x;
    logic signed [CORDW-1:0] y;
    logic [IDW-1:0]          id;
  } slot_t;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} sched_state_t;

  // The row offset is scaled down before the range check, so a 2x sprite covers 2*height lines.
  function automatic logic spr_visible(input spr_attr_t a, input logic signed [CORDW-1:0] tgt,
                                       input int scale, input int height);
    logic signed [CORDW-1:0] diff;
    diff = tgt - a.y;
    diff = diff >>> scale;
    return a.en && !diff[CORDW-1] && (int'(diff) < height);
  endfunction

endpackage

// File: rtl/spr_attr_table.sv
// Sprite attribute register file: one synchronous write port, one combinational read port,
// synchronous clear. Out-of-range write addresses are ignored.
module spr_attr_table
  import spr_sched_pkg::*;
#(
  parameter int  NUM_SPR = 16,
  localparam int AW      = $clog2(NUM_SPR)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  spr_attr_t     wdata,
  input  logic [AW-1:0] raddr,
  output spr_attr_t     rdata
);

  spr_attr_t mem [NUM_SPR];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPR; i++) mem[i] <= '0;
    end else if (we && int'(waddr) < NUM_SPR) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads see the pre-write contents, so a scan racing a write uses the old entry.
  assign rdata = mem[raddr];

endmodule

// File: rtl/sprite_scheduler.sv
// Per-scanline sprite scheduler: scans the attribute table once per line and fills
// double-buffered slot registers. Optional macro SPRITE_SCHED_COUNT_EN adds active_cnt.
module sprite_scheduler
  import spr_sched_pkg::*;
#(
  parameter int  NUM_SPR    = 16,
  parameter int  NUM_SLOTS  = 4,
  parameter int  SPR_HEIGHT = 8,
  parameter int  SPR_SCALE  = 0,
  localparam int AW         = $clog2(NUM_SPR),
  localparam int SW         = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        line_start,
  input  logic signed [CORDW-1:0]     tgt_y,
  input  logic                        cfg_we,
  input  logic [AW-1:0]               cfg_addr,
  input  logic signed [CORDW-1:0]     cfg_x,
  input  logic signed [CORDW-1:0]     cfg_y,
  input  logic [IDW-1:0]              cfg_id,
  input  logic                        cfg_en,
  output logic [NUM_SLOTS-1:0]        slot_valid,
  output logic [NUM_SLOTS*CORDW-1:0]  slot_x,
  output logic [NUM_SLOTS*CORDW-1:0]  slot_y,
  output logic [NUM_SLOTS*IDW-1:0]    slot_id,
  output logic                        overflow,
  output logic                        late,
  output logic                        busy
`ifdef SPRITE_SCHED_COUNT_EN
  ,
  output logic [$clog2(NUM_SPR+1)-1:0] active_cnt
`endif
);

  sched_state_t            state;
  logic [AW-1:0]           idx;
  logic signed [CORDW-1:0] tgt_y_r;
  slot_t                   shadow [NUM_SLOTS];
  slot_t                   live   [NUM_SLOTS];
  logic                    shadow_ovf;
  spr_attr_t               wattr;
  spr_attr_t               cur;
  logic                    vis;
  logic                    have_free;
  logic [SW-1:0]           free_idx;

  always_comb begin
    wattr = '{x: cfg_x, y: cfg_y, id: cfg_id, en: cfg_en};
  end

  spr_attr_table #(.NUM_SPR(NUM_SPR)) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (wattr),
    .raddr (idx),
    .rdata (cur)
  );

  assign vis = spr_visible(cur, tgt_y_r, SPR_SCALE, SPR_HEIGHT);

  // Slots fill in order, so the lowest empty slot is the next one to allocate.
  always_comb begin
    have_free = 1'b0;
    free_idx  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!shadow[i].valid) begin
        have_free = 1'b1;
        free_idx  = SW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      tgt_y_r    <= '0;
      busy       <= 1'b0;
      late       <= 1'b0;
      overflow   <= 1'b0;
      shadow_ovf <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shadow[i] <= '0;
        live[i]   <= '0;
      end
    end else if (line_start) begin
      // A new line always wins: publish whatever the shadow holds and restart the scan.
      if (state == SCAN) late <= 1'b1;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        live[i]   <= shadow[i];
        shadow[i] <= '0;
      end
      overflow   <= shadow_ovf;
      shadow_ovf <= 1'b0;
      tgt_y_r    <= tgt_y;
      idx        <= '0;
      state      <= SCAN;
      busy       <= 1'b1;
    end else if (state == SCAN) begin
      if (vis) begin
        if (have_free) shadow[free_idx] <= '{valid: 1'b1, x: cur.x, y: cur.y, id: cur.id};
        else           shadow_ovf       <= 1'b1;
      end
      if (int'(idx) == NUM_SPR - 1) begin
        state <= DONE;
        busy  <= 1'b0;
      end
      idx <= idx + 1'b1;
    end
  end

`ifdef SPRITE_SCHED_COUNT_EN
  logic [$clog2(NUM_SPR+1)-1:0] shadow_cnt;

  // Counts every visible entry, including those dropped for lack of a slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_cnt <= '0;
      active_cnt <= '0;
    end else if (line_start) begin
      active_cnt <= shadow_cnt;
      shadow_cnt <= '0;
    end else if (state == SCAN && vis) begin
      shadow_cnt <= shadow_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    slot_valid = '0;
    slot_x     = '0;
    slot_y     = '0;
    slot_id    = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_valid[i]               = live[i].valid;
      slot_x[i*CORDW +: CORDW]    = live[i].x;
      slot_y[i*CORDW +: CORDW]    = live[i].y;
      slot_id[i*IDW +: IDW]       = live[i].id;
    end
  end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler: table-driven visibility vectors plus hand-written
// sequences for overflow, vertical scaling, late line_start and same-cycle config writes.
module tb_sprite_scheduler;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               line_start = 1'b0;
  logic signed [15:0] tgt_y = '0;
  logic               cfg_we = 1'b0;
  logic [3:0]         cfg_addr = '0;
  logic signed [15:0] cfg_x = '0;
  logic signed [15:0] cfg_y = '0;
  logic [3:0]         cfg_id = '0;
  logic               cfg_en = 1'b0;

  logic [3:0]  slot_valid, slot_valid2;
  logic [63:0] slot_x, slot_x2;
  logic [63:0] slot_y, slot_y2;
  logic [15:0] slot_id, slot_id2;
  logic        overflow, overflow2, late, late2, busy, busy2;
`ifdef SPRITE_SCHED_COUNT_EN
  logic [4:0]  active_cnt, active_cnt2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sprite_scheduler dut (
    .clk(clk), .rst(rst), .line_start(line_start), .tgt_y(tgt_y),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .cfg_id(cfg_id), .cfg_en(cfg_en),
    .slot_valid(slot_valid), .slot_x(slot_x), .slot_y(slot_y), .slot_id(slot_id),
    .overflow(overflow), .late(late), .busy(busy)
`ifdef SPRITE_SCHED_COUNT_EN
    , .active_cnt(active_cnt)
`endif
  );

  // Second instance with 2x vertical scaling, driven by the same inputs.
  sprite_scheduler #(.SPR_SCALE(1)) dut2 (
    .clk(clk), .rst(rst), .line_start(line_start), .tgt_y(tgt_y),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .cfg_id(cfg_id), .cfg_en(cfg_en),
    .slot_valid(slot_valid2), .slot_x(slot_x2), .slot_y(slot_y2), .slot_id(slot_id2),
    .overflow(overflow2), .late(late2), .busy(busy2)
`ifdef SPRITE_SCHED_COUNT_EN
    , .active_cnt(active_cnt2)
`endif
  );

  typedef struct {
    logic signed [15:0] tgt;
    logic [3:0]         valid;
    logic [15:0]        x0;
    logic [15:0]        y0;
    logic [3:0]         id0;
    logic               ovf;
  } vec_t;

  vec_t vecs [5];

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic write_entry(input logic [3:0] a, input logic signed [15:0] x,
                             input logic signed [15:0] y, input logic [3:0] id, input logic en);
    cfg_we = 1'b1; cfg_addr = a; cfg_x = x; cfg_y = y; cfg_id = id; cfg_en = en;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_line(input logic signed [15:0] t);
    line_start = 1'b1;
    tgt_y = t;
    tick();
    line_start = 1'b0;
  endtask

  // Full scan of line t, then the next line_start publishes it; the follow-up scan is let finish.
  task automatic scan_and_commit(input logic signed [15:0] t);
    pulse_line(t);
    idle(16);
    pulse_line(t);
  endtask

  task automatic applyStimulus(input vec_t v);
    scan_and_commit(v.tgt);
    checkOutput("vec_valid", 64'(slot_valid), 64'(v.valid));
    checkOutput("vec_x0", 64'(slot_x[15:0]), 64'(v.x0));
    checkOutput("vec_y0", 64'(slot_y[15:0]), 64'(v.y0));
    checkOutput("vec_id0", 64'(slot_id[3:0]), 64'(v.id0));
    checkOutput("vec_ovf", 64'(overflow), 64'(v.ovf));
    idle(16);
  endtask

  initial begin
    vecs[0] = '{16'sd12, 4'b0001, 16'd100, 16'd5, 4'd2, 1'b0};
    vecs[1] = '{16'sd13, 4'b0000, 16'd0,   16'd0, 4'd0, 1'b0};
    vecs[2] = '{16'sd5,  4'b0001, 16'd100, 16'd5, 4'd2, 1'b0};
    vecs[3] = '{16'sd4,  4'b0000, 16'd0,   16'd0, 4'd0, 1'b0};
    vecs[4] = '{-16'sd3, 4'b0000, 16'd0,   16'd0, 4'd0, 1'b0};

    // Reset values and empty-table scan timing.
    do_reset();
    checkOutput("rst_valid", 64'(slot_valid), 64'd0);
    checkOutput("rst_x", slot_x, 64'd0);
    checkOutput("rst_ovf", 64'(overflow), 64'd0);
    checkOutput("rst_late", 64'(late), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    pulse_line(16'sd10);
    checkOutput("scan_busy_start", 64'(busy), 64'd1);
    idle(15);
    checkOutput("scan_busy_last", 64'(busy), 64'd1);
    tick();
    checkOutput("scan_busy_done", 64'(busy), 64'd0);
    pulse_line(16'sd10);
    checkOutput("empty_valid", 64'(slot_valid), 64'd0);
    checkOutput("empty_ovf", 64'(overflow), 64'd0);
    idle(16);

    // Single sprite at entry 3, several target lines.
    write_entry(4'd3, 16'sd100, 16'sd5, 4'd2, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    // Six visible sprites: first four take the slots, the rest overflow.
    do_reset();
    for (int i = 0; i < 6; i++) write_entry(4'(i), 16'(10 * i), 16'sd0, 4'(i), 1'b1);
    scan_and_commit(16'sd0);
    checkOutput("ovf_valid", 64'(slot_valid), 64'hF);
    checkOutput("ovf_x", slot_x, 64'h001E_0014_000A_0000);
    checkOutput("ovf_id", 64'(slot_id), 64'h3210);
    checkOutput("ovf_flag", 64'(overflow), 64'd1);
`ifdef SPRITE_SCHED_COUNT_EN
    checkOutput("ovf_cnt", 64'(active_cnt), 64'd6);
`endif
    checkOutput("ovf_late", 64'(late), 64'd0);
    idle(16);

    // Vertical scaling on dut2 (2x): 8-line sprite covers 16 lines.
    do_reset();
    write_entry(4'd0, 16'sd7, 16'sd0, 4'd1, 1'b1);
    write_entry(4'd1, 16'sd9, 16'sd20, 4'd3, 1'b1);
    scan_and_commit(16'sd15);
    checkOutput("scale_t15_valid", 64'(slot_valid2), 64'b0001);
    checkOutput("scale_t15_x", 64'(slot_x2[15:0]), 64'd7);
    checkOutput("noscale_t15_valid", 64'(slot_valid), 64'b0000);
    idle(16);
    scan_and_commit(16'sd16);
    checkOutput("scale_t16_valid", 64'(slot_valid2), 64'b0000);
    idle(16);
    scan_and_commit(16'sd19);
    checkOutput("scale_t19_valid", 64'(slot_valid2), 64'b0000);
    idle(16);
    scan_and_commit(16'sd20);
    checkOutput("scale_t20_valid", 64'(slot_valid2), 64'b0001);
    checkOutput("scale_t20_id", 64'(slot_id2[3:0]), 64'd3);
    idle(16);

    // line_start after entries 0..4 have been scanned: entry 5 must be missing.
    do_reset();
    write_entry(4'd4, 16'sd40, 16'sd0, 4'd4, 1'b1);
    write_entry(4'd5, 16'sd50, 16'sd0, 4'd5, 1'b1);
    pulse_line(16'sd0);
    idle(5);
    checkOutput("late_before", 64'(late), 64'd0);
    pulse_line(16'sd0);
    checkOutput("late_flag", 64'(late), 64'd1);
    checkOutput("late_valid", 64'(slot_valid), 64'b0001);
    checkOutput("late_x0", 64'(slot_x[15:0]), 64'd40);
`ifdef SPRITE_SCHED_COUNT_EN
    checkOutput("late_cnt", 64'(active_cnt), 64'd1);
`endif
    checkOutput("late_busy_start", 64'(busy), 64'd1);
    idle(15);
    checkOutput("late_busy_last", 64'(busy), 64'd1);
    tick();
    checkOutput("late_busy_done", 64'(busy), 64'd0);
    pulse_line(16'sd0);
    checkOutput("late_full_valid", 64'(slot_valid), 64'b0011);
    checkOutput("late_sticky", 64'(late), 64'd1);
    idle(16);

    // Disable entry 7 in the very cycle it is scanned.
    do_reset();
    write_entry(4'd7, 16'sd77, 16'sd0, 4'd7, 1'b1);
    pulse_line(16'sd0);
    idle(7);
    write_entry(4'd7, 16'sd77, 16'sd0, 4'd7, 1'b0);
    idle(8);
    checkOutput("race_busy_done", 64'(busy), 64'd0);
    pulse_line(16'sd0);
    checkOutput("race_valid", 64'(slot_valid), 64'b0001);
    checkOutput("race_x0", 64'(slot_x[15:0]), 64'd77);
    idle(16);
    pulse_line(16'sd0);
    checkOutput("race_next_valid", 64'(slot_valid), 64'b0000);
    checkOutput("race_late", 64'(late), 64'd0);
    idle(16);

    // Reset in the middle of a scan returns everything to zero.
    scan_and_commit(16'sd0);
    idle(3);
    do_reset();
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_valid", 64'(slot_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
